// File: rtl/store_port.sv
// store_port: memory-side responder for the store queue.
// Committed stores land in a small in-order write buffer. A store to the same
// word as the youngest entry is merged into that entry. The head entry is
// drained to memory with a req/ack handshake. Loads can pick up buffered bytes
// through byte-wise forwarding.

module store_port #(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  store_valid,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN/8-1:0]     store_mask,
    output logic                  store_avail,
    output logic                  store_accepted,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_data,
    output logic [XLEN/8-1:0]     mem_mask,
    input  logic                  mem_ack,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [XLEN-1:0]       ld_data,
    output logic [XLEN/8-1:0]     ld_mask,
    output logic                  empty
);

    localparam int MASK_W = XLEN / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WA_W   = ADDR_WIDTH - 2;

    // Entries keep only the word address; the byte offset is implied by the mask.
    logic [WA_W-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [MASK_W-1:0] mask_q [DEPTH];

    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              accepted_q;

    logic [PTR_W-1:0]  youngest;
    logic [WA_W-1:0]   store_word;
    logic              take;
    logic              do_merge;
    logic              do_alloc;
    logic              do_pop;
    logic [XLEN-1:0]   merge_data;
    logic [MASK_W-1:0] merge_mask;

    assign youngest   = tail_q - PTR_W'(1);
    assign store_word = store_addr[ADDR_WIDTH-1:2];

    // Availability depends only on the registered count. A slot freed by an
    // ack this cycle can therefore only be used from the next cycle on.
    assign store_avail = (count_q != CNT_W'(DEPTH));
    assign take        = store_valid && store_avail;

    // Merging requires at least two entries. With only one entry, the youngest
    // entry is the head, and the head is already on the memory port.
    assign do_merge = take && (|store_mask) && (count_q >= CNT_W'(2))
                      && (addr_q[youngest] == store_word);
    assign do_alloc = take && (|store_mask) && !do_merge;

    assign mem_req  = (count_q != '0);
    assign do_pop   = mem_req && mem_ack;
    assign mem_addr = {addr_q[head_q], 2'b00};
    assign mem_data = data_q[head_q];
    assign mem_mask = mask_q[head_q];

    assign store_accepted = accepted_q;
    assign empty          = (count_q == '0) && !accepted_q;

    // Byte-wise overlay of an incoming store onto the youngest entry.
    always_comb begin
        merge_data = data_q[youngest];
        merge_mask = mask_q[youngest] | store_mask;
        for (int b = 0; b < MASK_W; b++) begin
            if (store_mask[b]) begin
                merge_data[b*8 +: 8] = store_data[b*8 +: 8];
            end
        end
    end

    // Buffer state: allocation or merge at the tail, retirement at the head,
    // and the one-cycle accept pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            accepted_q <= 1'b0;
        end else begin
            accepted_q <= take;
            if (do_alloc) begin
                addr_q[tail_q] <= store_word;
                data_q[tail_q] <= store_data;
                mask_q[tail_q] <= store_mask;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (do_merge) begin
                data_q[youngest] <= merge_data;
                mask_q[youngest] <= merge_mask;
            end
            if (do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({do_alloc, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Forwarding: walk the live entries from oldest to newest. Younger hits
    // overwrite older ones, so each lane ends up with its newest matching byte.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        ld_data = '0;
        ld_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr[ADDR_WIDTH-1:2])) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (mask_q[idx][b]) begin
                        ld_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                        ld_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/store_port.md
# store_port

Memory-side responder for the store queue's store interface. Accepts one committed store per handshake from the store queue, holds it in a small in-order write buffer that merges same-word stores, and drains buffered words to the memory write port with a req/ack handshake. Also provides byte-wise store-to-load forwarding from buffered, not-yet-written data. Sits between the store queue and the data memory.

## Interface
- DEPTH, 4: write-buffer entries; power of two, at least 2.
- XLEN, 32: data width; byte mask is XLEN/8 bits.
- ADDR_WIDTH, 32: byte address width.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- store_valid  in  1  store queue offers a store this cycle.
- store_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- store_data  in  XLEN  store data, already lane-aligned.
- store_mask  in  XLEN/8  byte enables.
- store_avail  out  1  a store offered this cycle will be taken.
- store_accepted  out  1  one-cycle pulse, the cycle after a store was taken.
- mem_req  out  1  head entry presented to memory.
- mem_addr  out  ADDR_WIDTH  word address of head, low two bits zero.
- mem_data  out  XLEN  head data.
- mem_mask  out  XLEN/8  head byte enables.
- mem_ack  in  1  memory has taken the head this cycle.
- ld_addr  in  ADDR_WIDTH  forwarding probe address.
- ld_data  out  XLEN  forwarded bytes; lanes without a hit are zero.
- ld_mask  out  XLEN/8  lanes forwarded.
- empty  out  1  buffer holds no entries and no accept pulse is pending.

## Operation
- State: circular buffer of DEPTH entries {addr, data, mask}, head pointer, tail pointer, count of width clog2(DEPTH+1), registered accept-pulse flop.
- store_avail = (count != DEPTH). It depends only on registered count, never on store_valid or mem_ack.
- Take: store_valid && store_avail. If store_valid && !store_avail, the store is ignored and no pulse is issued. The queue must re-offer it.
- Take actions, in priority order:
  - Mask all zero: no allocation; the accept pulse still fires.
  - Merge: count >= 2 and word address equals the tail entry (the youngest). For each set mask bit, the tail byte is replaced and the tail mask bit is set.
  - Otherwise: allocate at tail, advance tail mod DEPTH, count+1.
  - Never merge into the head while count == 1, because the head is on the memory port.
- Drain: mem_req = (count != 0). mem_addr, mem_data and mem_mask come from the head entry and stay stable until mem_ack. On mem_req && mem_ack, the head advances mod DEPTH and count decrements. mem_ack while !mem_req is ignored.
- Simultaneous allocate and drain in one cycle: count is unchanged and both pointers advance.
- Forwarding, combinational: for each byte lane, take the newest entry whose word address matches ld_addr and whose mask bit is set. That includes the head while it is being drained. Newest means closest to tail.
- empty = (count == 0) && !store_accepted.

## Timing
- Reset values: count=0, head=tail=0, store_accepted=0. Consequently mem_req=0, store_avail=1, empty=1, ld_mask=0, ld_data=0. Entry contents are cleared.
- Accept latency: take in cycle N, store_accepted=1 in cycle N+1 only.
- Memory latency: an entry allocated in cycle N can appear on mem_req in N+1 at the earliest.
- Back-to-back: with mem_ack held high, one entry retires per cycle.
- Full: with count==DEPTH, store_avail=0 even if mem_ack=1 this cycle. It rises the cycle after the pop.
- Wrap-around: pointers wrap DEPTH-1 → 0 with no change in behaviour.
- Reset mid-operation: buffered entries and any pending accept pulse are discarded. The next cycle shows reset values, and mem_req drops even if no ack arrived.

## Test plan
- Single store: addr 0x100, data 0xDEADBEEF, mask 0xF after reset → store_accepted pulses next cycle. mem_req=1 with mem_addr 0x100 and data 0xDEADBEEF. On mem_ack, empty=1 the following cycle.
- Fill: 5 stores to distinct words with mem_ack=0 → 4 accepted and store_avail=0. The 5th gets no pulse. One mem_ack → store_avail=1 next cycle; the re-offered 5th is accepted.
- Merge: with head on the port (ack=0), store 0x200 mask 0x3 data 0x0000AAAA, then 0x202 mask 0xC data 0xBBBB0000 → second entry holds 0xBBBBAAAA mask 0xF. Count=2.
- Forwarding: entries 0x300 mask 0x1 data 0x11, then 0x300 mask 0x1 data 0x22 with the head in flight. ld_addr 0x300 → ld_data 0x22, ld_mask 0x1.
- Wrap: 10 stores with mem_ack held high → memory sees all 10 in order with no loss. Count never exceeds 2.
- Reset with 3 entries buffered and an accept pulse due → next cycle mem_req=0, store_accepted=0, empty=1, store_avail=1.
